// File: rtl/costas_phase_detector.sv
// costas_phase_detector
//
// Costas-loop phase detector for the 8 MHz loop. It integrates NCO-mixed I/Q
// baseband samples over blocks of N = 2**LOG2_N accepted samples. At the end of
// each block it dumps the sums and forms a 26-bit signed phase error for the
// loop filter. A hysteretic lock indicator is derived from the dump magnitudes.
//
// Build option (macro PD_MULT_EN):
//   undefined : decision-directed detector.
//               pd = q_dump, negated when i_dump < 0 (i_dump = 0 counts as positive).
//   defined   : full Costas multiplier.
//               pd = (i_dump * q_dump) >>> (2*AW - 26).
//
// Ports:
//   clk      in   system clock (8 MHz)
//   rst      in   asynchronous reset, active low
//   din_en   in   sample valid; i_in/q_in are accumulated only when high
//   i_in     in   signed in-phase mixer output, DW bits
//   q_in     in   signed quadrature mixer output, DW bits
//   pd       out  signed phase error, 26 bits, held between dumps
//   pd_valid out  one-cycle pulse when pd updates
//   locked   out  carrier lock indicator
//
// Width constraints: AW = DW + LOG2_N must satisfy AW <= 26 and 2*AW >= 26.

module costas_phase_detector #(
  parameter int DW       = 16,
  parameter int LOG2_N   = 3,
  parameter int LOCK_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_en,
  input  logic signed [DW-1:0] i_in,
  input  logic signed [DW-1:0] q_in,
  output logic signed [25:0]   pd,
  output logic                 pd_valid,
  output logic                 locked
);

  localparam int AW = DW + LOG2_N;
  localparam int PW = 26;
  localparam int LW = $clog2(LOCK_MAX + 1);

  // ---------------------------------------------------------------------------
  // Stage 1: integrate and dump
  // ---------------------------------------------------------------------------
  logic        [LOG2_N-1:0] cnt;
  logic signed [AW-1:0]     i_acc;
  logic signed [AW-1:0]     q_acc;
  logic signed [AW-1:0]     i_dump;
  logic signed [AW-1:0]     q_dump;
  logic                     dump_valid;

  logic signed [AW-1:0] i_ext;
  logic signed [AW-1:0] q_ext;
  logic signed [AW-1:0] i_sum;
  logic signed [AW-1:0] q_sum;
  logic                 last_sample;

  assign i_ext = {{LOG2_N{i_in[DW-1]}}, i_in};
  assign q_ext = {{LOG2_N{q_in[DW-1]}}, q_in};
  assign i_sum = i_acc + i_ext;
  assign q_sum = q_acc + q_ext;

  // cnt == N-1 is the all-ones pattern because N is a power of two.
  assign last_sample = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      i_acc      <= '0;
      q_acc      <= '0;
      i_dump     <= '0;
      q_dump     <= '0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (din_en) begin
        cnt <= cnt + 1'b1;  // natural wrap from N-1 to 0
        if (last_sample) begin
          // Dump includes the current sample.
          // Accumulators restart at zero so the next sample opens a fresh block.
          i_dump     <= i_sum;
          q_dump     <= q_sum;
          i_acc      <= '0;
          q_acc      <= '0;
          dump_valid <= 1'b1;
        end else begin
          i_acc <= i_sum;
          q_acc <= q_sum;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: phase error
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] pd_calc;

`ifdef PD_MULT_EN
  logic signed [2*AW-1:0] product;

  assign product = i_dump * q_dump;
  // Take the top PW bits: an arithmetic right shift by 2*AW-PW with floor rounding.
  assign pd_calc = product[2*AW-1 -: PW];
`else
  logic signed [PW-1:0] q_dump_ext;

  assign q_dump_ext = {{(PW-AW){q_dump[AW-1]}}, q_dump};
  // Negating the most negative q_dump cannot wrap, because PW > AW.
  assign pd_calc = i_dump[AW-1] ? -q_dump_ext : q_dump_ext;
`endif

  // ---------------------------------------------------------------------------
  // Lock detector: |i_dump| > 2*|q_dump|
  // ---------------------------------------------------------------------------
  // Magnitudes are computed at AW+2 bits.
  // This holds |min| = 2**(AW-1) and twice it without overflow.
  logic signed [AW+1:0] i_wide;
  logic signed [AW+1:0] q_wide;
  logic signed [AW+1:0] i_mag;
  logic signed [AW+1:0] q_mag2;
  logic                 lock_up;
  logic        [LW-1:0] lock_cnt;
  logic        [LW-1:0] lock_next;

  assign i_wide  = {{2{i_dump[AW-1]}}, i_dump};
  assign q_wide  = {{2{q_dump[AW-1]}}, q_dump};
  assign i_mag   = i_dump[AW-1] ? -i_wide : i_wide;
  assign q_mag2  = (q_dump[AW-1] ? -q_wide : q_wide) <<< 1;
  assign lock_up = i_mag > q_mag2;

  always_comb begin
    lock_next = lock_cnt;
    if (lock_up) begin
      if (lock_cnt != LW'(LOCK_MAX)) lock_next = lock_cnt + 1'b1;
    end else begin
      if (lock_cnt != '0) lock_next = lock_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pd       <= '0;
      pd_valid <= 1'b0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      pd_valid <= dump_valid;
      if (dump_valid) begin
        pd       <= pd_calc;
        lock_cnt <= lock_next;
        // Hysteresis: set only at full count, clear only at empty, else hold.
        if (lock_next == LW'(LOCK_MAX)) begin
          locked <= 1'b1;
        end else if (lock_next == '0) begin
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_costas_phase_detector.sv
`timescale 1ns/1ps

module tb_costas_phase_detector;

  localparam int DW       = 16;
  localparam int LOG2_N   = 3;
  localparam int LOCK_MAX = 15;
  localparam int N        = 1 << LOG2_N;
  localparam int AW       = DW + LOG2_N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 din_en = 1'b0;
  logic signed [DW-1:0] i_in = '0;
  logic signed [DW-1:0] q_in = '0;
  logic signed [25:0]   pd;
  logic                 pd_valid;
  logic                 locked;

  costas_phase_detector #(
    .DW(DW), .LOG2_N(LOG2_N), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst), .din_en(din_en), .i_in(i_in), .q_in(q_in),
    .pd(pd), .pd_valid(pd_valid), .locked(locked)
  );

  always #62 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: block sums, then the phase-error and lock rules
  // ---------------------------------------------------------------------------
  typedef struct {
    logic signed [25:0] pd;
    logic               lk;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];

  int blk_i  = 0;
  int blk_q  = 0;
  int blk_n  = 0;
  int lock_c = 0;
  bit lock_s = 0;

  task automatic model_reset();
    blk_i  = 0;
    blk_q  = 0;
    blk_n  = 0;
    lock_c = 0;
    lock_s = 0;
  endtask

  task automatic model_accept(int i, int q, int out_cyc);
    longint p;
    int     ai;
    int     aq;
    exp_t   e;
    blk_i += i;
    blk_q += q;
    blk_n++;
    if (blk_n == N) begin
`ifdef PD_MULT_EN
      p = (longint'(blk_i) * longint'(blk_q)) >>> (2*AW - 26);
`else
      p = (blk_i < 0) ? -longint'(blk_q) : longint'(blk_q);
`endif
      ai = (blk_i < 0) ? -blk_i : blk_i;
      aq = (blk_q < 0) ? -blk_q : blk_q;
      if (ai > 2*aq) lock_c = (lock_c < LOCK_MAX) ? lock_c + 1 : LOCK_MAX;
      else           lock_c = (lock_c > 0) ? lock_c - 1 : 0;
      if (lock_c == LOCK_MAX) lock_s = 1;
      else if (lock_c == 0)   lock_s = 0;
      e.pd  = p[25:0];
      e.lk  = lock_s;
      e.cyc = out_cyc;
      exp_q.push_back(e);
      blk_i = 0;
      blk_q = 0;
      blk_n = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic send(bit en, int i, int q);
    @(negedge clk);
    din_en = en;
    i_in   = i[DW-1:0];
    q_in   = q[DW-1:0];
    // Sample is captured at the next rising edge.
    // Its dump result is visible one edge later, i.e. at cyc + 2.
    if (en) model_accept(i, q, cyc + 2);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) send(1'b0, 0, 0);
  endtask

  task automatic blocks(int nb, int i, int q);
    for (int k = 0; k < nb*N; k++) send(1'b1, i, q);
  endtask

  task automatic reset_dut();
    idle(3);
    chk("queue_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_pd", pd, 0);
    chk("reset_pd_valid", pd_valid, 0);
    chk("reset_locked", locked, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_pd", pd, 0);
    chk("post_reset_locked", locked, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard whenever pd_valid is seen
  // ---------------------------------------------------------------------------
  logic signed [25:0] last_pd = '0;
  logic               prev_v  = 1'b0;
  exp_t               mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      last_pd = '0;
      prev_v  = 1'b0;
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("missed_pd_valid", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (pd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pd_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pd", pd, mon_e.pd);
          chk("locked", locked, mon_e.lk);
          chk("pd_valid_cycle", cyc, mon_e.cyc);
        end
        chk("pd_valid_back_to_back", prev_v, 0);
        last_pd = pd;
      end else begin
        chk("pd_hold", pd, last_pd);
      end
      prev_v = pd_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ri;
    int rq;

    reset_dut();

    // Basic dumps: +800 and then -800 (decision-directed build).
    blocks(1, 1000, 100);
    blocks(1, -1000, 100);

    // Continuous strong-I stimulus until lock.
    // Weak-I stimulus then drains the counter, with the clear landing on the 15th dump.
    blocks(13, 1000, 100);
    blocks(15, 0, 1000);
    idle(2);

    // din_en toggling stretches the dump period to 16 clocks.
    for (int k = 0; k < 2*N; k++) send(k % 2 == 0, 1000, 100);
    idle(2);

    // Mid-block reset: the partial sums of 5 samples must not leak into the next dump.
    for (int k = 0; k < 5; k++) send(1'b1, 1000, 100);
    reset_dut();
    blocks(1, 1000, -50);

    // Full-scale negative inputs.
    blocks(1, -32768, -32768);
    idle(2);

    // Randomized stimulus with gaps, mixed magnitudes and one reset in the middle.
    for (int k = 0; k < 600; k++) begin
      if (k == 300) reset_dut();
      ri = int'($urandom_range(0, 65535)) - 32768;
      rq = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 2) == 0) rq = rq / 16;
      if ($urandom_range(0, 3) == 0) ri = ri / 64;
      send($urandom_range(0, 3) != 0, ri, rq);
    end

    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/costas_phase_detector.md
# costas_phase_detector

Costas-loop phase detector feeding the loop filter on the 8 MHz system clock. Integrates the NCO-mixed I and Q baseband samples over a fixed block of N samples (integrate-and-dump), forms a 26-bit signed phase error `pd`, and holds it for the loop filter. It also provides a hysteretic lock indicator derived from the I/Q dump magnitudes.

## Interface
- `DW`, 16: width of signed I/Q input samples
- `LOG2_N`, 3: log2 of samples per dump (N = 8, matching the 8-clock frequency-word update period)
- `LOCK_MAX`, 15: saturation value of the lock counter (counter width 4 bits at default)
- `clk` in 1: FPGA system clock, 8 MHz
- `rst` in 1: asynchronous reset, active-low
- `din_en` in 1: input sample valid; `i_in`/`q_in` are accumulated only when high
- `i_in` in DW: signed in-phase mixer output
- `q_in` in DW: signed quadrature mixer output
- `pd` out 26: signed phase error, held between dumps
- `pd_valid` out 1: one-cycle pulse when `pd` updates
- `locked` out 1: carrier lock indicator

## Operation
- AW = DW+LOG2_N (19 at default). Constraints: AW ≤ 26 and 2·AW ≥ 26.
- Accumulators `i_acc` and `q_acc` (AW-bit signed) and sample counter `cnt` (LOG2_N bits) are all cleared by reset.
- On `din_en`=1: add the sign-extended sample to the accumulators and increment `cnt`. `cnt` wraps from N−1 to 0.
- Dump (accepted sample with `cnt`==N−1):
  - Register accumulator+sample into `i_dump`/`q_dump`.
  - Load the accumulators with 0, so the next accepted sample starts a fresh block with no dead cycle.
- On `din_en`=0: accumulators and `cnt` hold.
- Stage 2 (cycle after dump), phase error per Configuration:
  - `pd` registered; `pd_valid`=1 for exactly that cycle.
  - Lock counter updated the same cycle.
- Lock counter:
  - Saturating 0..LOCK_MAX.
  - Increment when |i_dump| > 2·|q_dump|; otherwise decrement.
  - Compare at AW+2 bits, so no overflow.
- `locked`:
  - Set when the counter reaches LOCK_MAX.
  - Cleared when it reaches 0.
  - Holds otherwise (hysteresis).
- Sign/magnitude overflow is impossible by width choice; no saturation on `pd`.

## Timing
- Reset values: `pd`=0, `pd_valid`=0, `locked`=0, all internal registers 0.
- Reset is asynchronous in effect. Mid-block reset discards the partial sums; the next dump requires N new accepted samples.
- Latency: the Nth sample sampled at edge E → `pd`/`pd_valid` visible after edge E+1.
- With `din_en` continuously high, `pd_valid` pulses every N clocks (every 8th cycle).
- `din_en` gaps stretch the dump period; `pd` holds its last value throughout.
- `pd_valid` never asserts twice in consecutive cycles when N ≥ 2.

## Configuration
- `PD_MULT_EN` undefined (default, decision-directed):
  - `pd` = sign-extend(q_dump) to 26 bits, negated when i_dump < 0.
  - i_dump = 0 counts as positive.
- `PD_MULT_EN` defined (full Costas multiplier):
  - product = i_dump·q_dump (2·AW bits signed).
  - `pd` = product >>> (2·AW−26), i.e. arithmetic shift, floor rounding; bits [37:12] at default.
- Lock detector and timing are identical in both builds.

## Test plan
- `din_en`=1, I=+1000, Q=+100 for 8 cycles → one `pd_valid` pulse.
  - Default build: `pd`=800.
  - `PD_MULT_EN` build: `pd`=6,400,000>>12=1562.
- I=−1000, Q=+100 for 8 cycles → default build: `pd`=−800.
- Same stimulus continuous:
  - 15th dump → `locked`=1.
  - Then I=0, Q=+1000: `locked` stays 1 through 14 dumps and clears on the 15th.
- `din_en` toggling 1,0,1,0… with I=+1000, Q=+100 → `pd_valid` every 16 clocks, `pd`=800.
- `rst` low after 5 accepted samples, then 8 samples of I=+1000, Q=−50 → default build: `pd`=−400 (no residue), `locked`=0 throughout.
- Full scale: I=Q=−32768 for 8 cycles:
  - Default build: `pd`=+262144.
  - `PD_MULT_EN` build: `pd`=2^36>>12=16,777,216.
  - No wrap in either build.
